// File: rtl/except_ctrl_pkg.sv
// Shared CP0 register addresses, excepttype codes, raw flag positions and FSM states.
// latency: n/a (definitions only); backpressure: n/a.
package except_ctrl_pkg;

    localparam logic [4:0] CP0_REG_STATUS = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_REG_EPC    = 5'd14;

    localparam logic [31:0] EXC_NONE      = 32'h0;
    localparam logic [31:0] EXC_INTERRUPT = 32'h1;
    localparam logic [31:0] EXC_SYSCALL   = 32'h8;
    localparam logic [31:0] EXC_INV_INST  = 32'ha;
    localparam logic [31:0] EXC_TRAP      = 32'hd;
    localparam logic [31:0] EXC_OVERFLOW  = 32'hc;
    localparam logic [31:0] EXC_ERET      = 32'he;

    localparam int FLAG_SYSCALL  = 8;
    localparam int FLAG_INV_INST = 9;
    localparam int FLAG_TRAP     = 10;
    localparam int FLAG_OVERFLOW = 11;
    localparam int FLAG_ERET     = 12;

    // Cause bits software may write: IP[1:0] (9:8), IV (23) and WP (22).
    localparam logic [31:0] CAUSE_WB_MASK = 32'h00C0_0300;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_HOLD
    } exc_state_e;

endpackage

// File: rtl/except_ctrl_cp0_fwd.sv
// Forwards a WB-stage CP0 write onto the Status/Cause/EPC values seen by MEM.
// latency: combinational; backpressure: none.
module except_ctrl_cp0_fwd
    import except_ctrl_pkg::*;
(
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    output logic [31:0] status_f_o,
    output logic [31:0] cause_f_o,
    output logic [31:0] epc_f_o
);

    always_comb begin
        status_f_o = cp0_status_i;
        cause_f_o  = cp0_cause_i;
        epc_f_o    = cp0_epc_i;
        if (wb_cp0_we_i) begin
            unique case (wb_cp0_waddr_i)
                CP0_REG_STATUS: status_f_o = wb_cp0_data_i;
                CP0_REG_CAUSE:  cause_f_o  = (cp0_cause_i & ~CAUSE_WB_MASK) |
                                             (wb_cp0_data_i & CAUSE_WB_MASK);
                CP0_REG_EPC:    epc_f_o    = wb_cp0_data_i;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/except_ctrl.sv
// MEM-stage exception resolver: prioritised excepttype to CP0, registered flush/redirect.
// latency: code same cycle, flush_o/new_pc_o one cycle later; backpressure: stall_i only blocks detection.
module except_ctrl
    import except_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int          FLUSH_HOLD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [31:0] exc_count_o
);

    localparam logic [2:0] HOLD_INIT = 3'(FLUSH_HOLD - 1);

    logic [31:0] status_f, cause_f, epc_f;
    exc_state_e  state_q, state_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  hold_q, hold_d;
    logic        det_en, int_pend;
    logic [31:0] exc_code;
    logic        unused_bits;

    except_ctrl_cp0_fwd u_cp0_fwd (
        .wb_cp0_we_i    (wb_cp0_we_i),
        .wb_cp0_waddr_i (wb_cp0_waddr_i),
        .wb_cp0_data_i  (wb_cp0_data_i),
        .cp0_status_i   (cp0_status_i),
        .cp0_cause_i    (cp0_cause_i),
        .cp0_epc_i      (cp0_epc_i),
        .status_f_o     (status_f),
        .cause_f_o      (cause_f),
        .epc_f_o        (epc_f)
    );

    // rst gates detection so CP0 never sees a code while the block is in reset.
    assign det_en   = rst && (state_q == ST_RUN) && !stall_i && (current_inst_addr_i != 32'h0);
    assign int_pend = (|(cause_f[15:8] & status_f[15:8])) && !status_f[1] && status_f[0];

    always_comb begin
        exc_code = EXC_NONE;
        if (det_en) begin
            if (int_pend)                          exc_code = EXC_INTERRUPT;
            else if (excepttype_i[FLAG_SYSCALL])   exc_code = EXC_SYSCALL;
            else if (excepttype_i[FLAG_INV_INST])  exc_code = EXC_INV_INST;
            else if (excepttype_i[FLAG_TRAP])      exc_code = EXC_TRAP;
            else if (excepttype_i[FLAG_OVERFLOW])  exc_code = EXC_OVERFLOW;
            else if (excepttype_i[FLAG_ERET])      exc_code = EXC_ERET;
        end
    end

    always_comb begin
        state_d  = state_q;
        flush_d  = 1'b0;
        new_pc_d = new_pc_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        unique case (state_q)
            ST_RUN: begin
                if (exc_code != EXC_NONE) begin
                    flush_d  = 1'b1;
                    new_pc_d = (exc_code == EXC_ERET) ? epc_f : EXC_VECTOR;
                    if (exc_code != EXC_ERET) cnt_d = cnt_q + 32'd1;
                    state_d  = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                hold_d  = HOLD_INIT;
                state_d = (HOLD_INIT == 3'd0) ? ST_RUN : ST_HOLD;
            end
            ST_HOLD: begin
                hold_d = hold_q - 3'd1;
                if (hold_q <= 3'd1) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            flush_q  <= 1'b0;
            new_pc_q <= 32'h0;
            cnt_q    <= 32'h0;
            hold_q   <= 3'd0;
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            new_pc_q <= new_pc_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
        end
    end

    assign excepttype_o        = exc_code;
    assign current_inst_addr_o = current_inst_addr_i;
    assign is_in_delayslot_o   = is_in_delayslot_i;
    assign flush_o             = flush_q;
    assign new_pc_o            = new_pc_q;
    assign exc_count_o         = cnt_q;

    assign unused_bits = ^{excepttype_i[31:13], excepttype_i[7:0], status_f[31:16],
                           status_f[7:2], cause_f[31:16], cause_f[7:0]};

endmodule

// File: tb/tb_except_ctrl.sv
// Bench for except_ctrl: directed literal cases, then random traffic against a behavioural model.
module tb_except_ctrl;

    localparam int          FLUSH_HOLD = 2;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0020;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [31:0] exc = '0, addr = '0, status = '0, cause = '0, epc = '0, wdata = '0;
    logic        ds = 1'b0, we = 1'b0;
    logic [4:0]  waddr = '0;

    logic [31:0] excepttype_o, current_inst_addr_o, new_pc_o, exc_count_o;
    logic        is_in_delayslot_o, flush_o;

    always #5 clk = ~clk;

    except_ctrl #(.EXC_VECTOR(EXC_VECTOR), .FLUSH_HOLD(FLUSH_HOLD)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall_i             (stall),
        .excepttype_i        (exc),
        .current_inst_addr_i (addr),
        .is_in_delayslot_i   (ds),
        .cp0_status_i        (status),
        .cp0_cause_i         (cause),
        .cp0_epc_i           (epc),
        .wb_cp0_we_i         (we),
        .wb_cp0_waddr_i      (waddr),
        .wb_cp0_data_i       (wdata),
        .excepttype_o        (excepttype_o),
        .current_inst_addr_o (current_inst_addr_o),
        .is_in_delayslot_o   (is_in_delayslot_o),
        .flush_o             (flush_o),
        .new_pc_o            (new_pc_o),
        .exc_count_o         (exc_count_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a countdown of suppressed cycles plus the last redirect/flush/count.
    logic        m_flush = 1'b0;
    logic [31:0] m_pc = '0, m_cnt = '0, m_code;
    int          m_block = 0;

    function automatic logic [31:0] ref_epc();
        return (we && waddr == 5'd14) ? wdata : epc;
    endfunction

    function automatic logic [31:0] ref_code();
        logic [31:0] st, ca;
        st = (we && waddr == 5'd12) ? wdata : status;
        ca = cause;
        if (we && waddr == 5'd13)
            ca = {cause[31:24], wdata[23:22], cause[21:10], wdata[9:8], cause[7:0]};
        if (!rst || m_block != 0 || stall || addr == 32'h0) return 32'h0;
        if ((ca[15:8] & st[15:8]) != 8'h0 && !st[1] && st[0]) return 32'h1;
        if (exc[8])  return 32'h8;
        if (exc[9])  return 32'ha;
        if (exc[10]) return 32'hd;
        if (exc[11]) return 32'hc;
        if (exc[12]) return 32'he;
        return 32'h0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_flush = 1'b0; m_pc = '0; m_cnt = '0; m_block = 0;
        end else begin
            m_code  = ref_code();
            m_flush = 1'b0;
            if (m_block != 0) m_block--;
            else if (m_code != 32'h0) begin
                m_flush = 1'b1;
                m_pc    = (m_code == 32'he) ? ref_epc() : EXC_VECTOR;
                if (m_code != 32'he) m_cnt++;
                m_block = FLUSH_HOLD;
            end
        end
    end

    always @(negedge clk) begin
        check("excepttype", excepttype_o, ref_code());
        check("addr_pass", current_inst_addr_o, addr);
        check("ds_pass", {31'b0, is_in_delayslot_o}, {31'b0, ds});
        check("flush", {31'b0, flush_o}, {31'b0, m_flush});
        check("new_pc", new_pc_o, m_pc);
        check("exc_count", exc_count_o, m_cnt);
    end

    task automatic drive(input logic st_i, input logic [31:0] ex_i, input logic [31:0] a_i,
                         input logic [31:0] sts_i, input logic [31:0] ca_i, input logic [31:0] ep_i,
                         input logic we_i, input logic [4:0] wa_i, input logic [31:0] wd_i);
        stall = st_i; exc = ex_i; addr = a_i; ds = a_i[2];
        status = sts_i; cause = ca_i; epc = ep_i; we = we_i; waddr = wa_i; wdata = wd_i;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] a_i);
        drive(1'b0, 32'h0, a_i, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    initial begin
        idle(32'h0);
        #1 rst = 1'b0;
        drive(1'b0, 32'h100, 32'h100, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_exc", excepttype_o, 32'h0);
        check("rst_flush", {31'b0, flush_o}, 32'h0);
        check("rst_pc", new_pc_o, 32'h0);
        check("rst_cnt", exc_count_o, 32'h0);
        #2 rst = 1'b1;
        #1 check("sys_code", excepttype_o, 32'h8);
        next(); idle(32'h104);
        @(negedge clk);
        check("sys_flush", {31'b0, flush_o}, 32'h1);
        check("sys_pc", new_pc_o, 32'h20);
        check("sys_cnt", exc_count_o, 32'h1);
        repeat (FLUSH_HOLD) next();

        drive(1'b0, 32'h0, 32'h200, 32'h401, 32'h400, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk); check("int_code", excepttype_o, 32'h1);
        next(); idle(32'h204);
        @(negedge clk); check("int_cnt", exc_count_o, 32'h2);
        repeat (FLUSH_HOLD) next();
        drive(1'b0, 32'h0, 32'h208, 32'h403, 32'h400, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk); check("int_masked", excepttype_o, 32'h0);
        next();

        drive(1'b0, 32'h1000, 32'h300, 32'h0, 32'h0, 32'h40, 1'b1, 5'd14, 32'h80);
        @(negedge clk); check("eret_code", excepttype_o, 32'he);
        next(); idle(32'h304);
        @(negedge clk);
        check("eret_flush", {31'b0, flush_o}, 32'h1);
        check("eret_pc", new_pc_o, 32'h80);
        check("eret_cnt", exc_count_o, 32'h2);
        repeat (FLUSH_HOLD) next();

        drive(1'b0, 32'h1100, 32'h400, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk); check("hold_sys_wins", excepttype_o, 32'h8);
        next(); drive(1'b0, 32'h100, 32'h404, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk); check("hold_c1", excepttype_o, 32'h0); check("hold_f1", {31'b0, flush_o}, 32'h1);
        next(); drive(1'b0, 32'h100, 32'h408, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk); check("hold_c2", excepttype_o, 32'h0); check("hold_f2", {31'b0, flush_o}, 32'h0);
        next(); drive(1'b0, 32'h100, 32'h40c, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk); check("hold_c3", excepttype_o, 32'h8);
        next(); idle(32'h410);
        @(negedge clk); check("hold_cnt", exc_count_o, 32'h4);
        repeat (FLUSH_HOLD) next();

        drive(1'b0, 32'h200, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk); check("bubble", excepttype_o, 32'h0);
        next(); drive(1'b1, 32'h800, 32'h500, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk); check("stall", excepttype_o, 32'h0);
        next(); drive(1'b0, 32'h800, 32'h500, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk); check("ovf_code", excepttype_o, 32'hc);
        next(); idle(32'h504);
        #1 check("pre_rst_flush", {31'b0, flush_o}, 32'h1);
        rst = 1'b0;
        #1;
        check("arst_flush", {31'b0, flush_o}, 32'h0);
        check("arst_cnt", exc_count_o, 32'h0);
        drive(1'b0, 32'h100, 32'h600, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1 rst = 1'b1;
        #1 check("arst_run", excepttype_o, 32'h8);
        next(); idle(32'h604);
        @(negedge clk); check("arst_cnt1", exc_count_o, 32'h1);
        repeat (FLUSH_HOLD) next();

        for (int i = 0; i < 3000; i++) begin
            stall  = ($urandom_range(0, 7) == 0);
            addr   = ($urandom_range(0, 9) == 0) ? 32'h0 : $urandom;
            ds     = 1'($urandom_range(0, 1));
            exc    = $urandom;
            if ($urandom_range(0, 2) != 0) exc = exc & ~32'h0000_1f00;
            status = $urandom;
            cause  = $urandom;
            epc    = $urandom;
            we     = 1'($urandom_range(0, 1));
            waddr  = 5'($urandom_range(10, 16));
            wdata  = $urandom;
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b0;
                #2 rst = 1'b1;
            end
            next();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
